// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: PC, imem handshake, IF/ID register with skid,
// branch redirect with flush and discard of stale responses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master imem,
    input  logic               id_stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [31:0]        if_pc4,
    output logic [5:0]         opcode
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] reqAddr, reqAddrNext;
    logic [31:0] skidInstr, skidInstrNext;
    logic [31:0] skidPc4, skidPc4Next;
    logic [31:0] instrNext, pc4Next;
    logic        validNext;
    logic        slotFree;
    logic [31:0] target;
    logic [31:0] reqInc;

    assign slotFree       = !if_valid || !id_stall;
    assign target         = branch_target & ~32'd3;
    assign reqInc         = reqAddr + 32'd4;
    assign imem.imem_req  = (state == FETCH) || (state == DROP);
    assign imem.imem_addr = reqAddr;
    assign opcode         = if_instr[31:26];

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        reqAddrNext   = reqAddr;
        skidInstrNext = skidInstr;
        skidPc4Next   = skidPc4;
        instrNext     = if_instr;
        pc4Next       = if_pc4;
        validNext     = if_valid && !slotFree;
        if (branch_taken) begin
            validNext = 1'b0;
            pcNext    = target;
        end
        case (state)
            IDLE: begin
                stateNext   = FETCH;
                reqAddrNext = branch_taken ? target : pc;
            end
            FETCH: begin
                if (branch_taken) begin
                    // an in-flight request must be drained before redirecting
                    if (imem.imem_rvalid) reqAddrNext = target;
                    else                  stateNext   = DROP;
                end else if (imem.imem_rvalid) begin
                    pcNext = reqInc;
                    if (slotFree) begin
                        validNext   = 1'b1;
                        instrNext   = imem.imem_rdata;
                        pc4Next     = reqInc;
                        reqAddrNext = reqInc;
                    end else begin
                        skidInstrNext = imem.imem_rdata;
                        skidPc4Next   = reqInc;
                        stateNext     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    reqAddrNext = target;
                    stateNext   = FETCH;
                end else if (slotFree) begin
                    validNext   = 1'b1;
                    instrNext   = skidInstr;
                    pc4Next     = skidPc4;
                    reqAddrNext = pc;
                    stateNext   = FETCH;
                end
            end
            DROP: begin
                if (imem.imem_rvalid) begin
                    reqAddrNext = pcNext;
                    stateNext   = FETCH;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            reqAddr   <= RESET_PC;
            if_valid  <= 1'b0;
            if_instr  <= 32'd0;
            if_pc4    <= 32'd0;
            skidInstr <= 32'd0;
            skidPc4   <= 32'd0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            reqAddr   <= reqAddrNext;
            if_valid  <= validNext;
            if_instr  <= instrNext;
            if_pc4    <= pc4Next;
            skidInstr <= skidInstrNext;
            skidPc4   <= skidPc4Next;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random stall/branch/latency
// traffic checked against an in-order instruction stream model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RP  = 32'h0000_0000;
    localparam logic [31:0] RP2 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc4;
    logic [5:0]  opcode;
    logic        w2Valid;
    logic [31:0] w2Instr, w2Pc4;
    logic [5:0]  w2Op;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus2 ();

    always #5 clk = ~clk;

    // second unit sits on an always-ready memory to exercise the wrapping reset PC
    assign bus2.imem_rvalid = bus2.imem_req;
    assign bus2.imem_rdata  = bus2.imem_addr >> 2;

    instr_fetch_unit #(.RESET_PC(RP)) dut (
        .clk(clk), .reset(reset), .imem(bus.master),
        .id_stall(id_stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc4(if_pc4), .opcode(opcode)
    );

    instr_fetch_unit #(.RESET_PC(RP2)) dutWrap (
        .clk(clk), .reset(reset), .imem(bus2.master),
        .id_stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'd0), .if_valid(w2Valid),
        .if_instr(w2Instr), .if_pc4(w2Pc4), .opcode(w2Op)
    );

    int          total = 0;
    int          bad = 0;
    int          consumed = 0;
    logic [31:0] fetchExp = RP;
    logic [31:0] consumeExp = RP;
    logic [31:0] pendAddr = 32'd0;
    bit          pend = 0;
    int          cnt = 0;
    bit          expReset = 0;
    bit          expNoValid = 0;
    int          fixedLat = 0;
    int          maxLat = 0;
    bit          rawData = 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (rawData) return a >> 2;
        return {a[7:2] ^ a[13:8], a[27:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Called at a falling edge: checks this cycle's outputs, drives this
    // cycle's inputs and memory response, then advances to the next falling edge.
    task automatic cycle(input bit rst, input bit stall, input bit br,
                         input logic [31:0] tgt);
        int          lat;
        logic [31:0] w;
        if (expReset) begin
            chk1("rst_valid", if_valid, 1'b0);
            chk("rst_instr", if_instr, 32'd0);
            chk("rst_pc4", if_pc4, 32'd0);
            chk("rst_opcode", {26'd0, opcode}, 32'd0);
            chk1("rst_req", bus.imem_req, 1'b0);
        end
        if (expNoValid) chk1("branch_flush", if_valid, 1'b0);
        reset         = rst;
        id_stall      = stall;
        branch_taken  = br;
        branch_target = tgt;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (rst) begin
            pend = 0;
        end else if (pend) begin
            chk1("req_held", bus.imem_req, 1'b1);
            chk("addr_held", bus.imem_addr, pendAddr);
            cnt--;
            if (cnt == 0) begin
                pend = 0;
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memWord(pendAddr);
            end
        end else if (bus.imem_req) begin
            chk("fetch_addr", bus.imem_addr, fetchExp);
            pendAddr = bus.imem_addr;
            fetchExp = fetchExp + 32'd4;
            lat = (fixedLat >= 0) ? fixedLat : int'($urandom_range(maxLat, 0));
            if (lat == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = memWord(pendAddr);
            end else begin
                pend = 1;
                cnt  = lat;
            end
        end
        if (!rst && if_valid) begin
            w = memWord(consumeExp);
            chk("ifid_pc4", if_pc4, consumeExp + 32'd4);
            chk("ifid_instr", if_instr, w);
            chk("ifid_opcode", {26'd0, opcode}, {26'd0, w[31:26]});
            if (!stall) begin
                consumeExp = consumeExp + 32'd4;
                consumed++;
            end
        end
        if (!rst && br) begin
            fetchExp   = tgt & ~32'd3;
            consumeExp = tgt & ~32'd3;
        end
        if (rst) begin
            fetchExp   = RP;
            consumeExp = RP;
        end
        expReset   = rst;
        expNoValid = br && !rst;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        @(negedge clk);

        // reset and zero-wait stream
        rawData  = 1;
        fixedLat = 0;
        cycle(1, 0, 0, 32'd0);
        cycle(1, 0, 0, 32'd0);
        chk1("c0_req", bus.imem_req, 1'b0);
        chk1("c0_valid", if_valid, 1'b0);
        cycle(0, 0, 0, 32'd0);
        chk1("c1_req", bus.imem_req, 1'b1);
        chk("c1_addr", bus.imem_addr, 32'd0);
        chk1("c1_valid", if_valid, 1'b0);
        chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 32'd0);
            chk1("s1_valid", if_valid, 1'b1);
            chk("s1_instr", if_instr, 32'(k));
            chk("s1_pc4", if_pc4, 32'(4 * k + 4));
            chk("s1_addr", bus.imem_addr, 32'(4 * k + 4));
            if (k == 0) begin
                chk1("wrap_valid", w2Valid, 1'b1);
                chk("wrap_pc4", w2Pc4, 32'd0);
                chk("wrap_instr", w2Instr, 32'h3FFF_FFFF);
                chk("wrap_addr1", bus2.imem_addr, 32'd0);
            end
        end

        // three-cycle stall with skid
        cycle(0, 1, 0, 32'd0);
        chk1("stall_req", bus.imem_req, 1'b0);
        chk("stall_instr", if_instr, 32'd3);
        cycle(0, 1, 0, 32'd0);
        cycle(0, 1, 0, 32'd0);
        cycle(0, 0, 0, 32'd0);
        chk("resume_instr", if_instr, 32'd4);
        chk("resume_pc4", if_pc4, 32'd20);
        chk1("resume_req", bus.imem_req, 1'b1);
        chk("resume_addr", bus.imem_addr, 32'd20);

        // branch while a 3-cycle fetch is outstanding
        fixedLat = 3;
        cycle(1, 0, 0, 32'd0);
        cycle(1, 0, 0, 32'd0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (bus.imem_req && bus.imem_addr == 32'd8) found = 1;
            else cycle(0, 0, 0, 32'd0);
        end
        chk1("reach_addr8", found, 1'b1);
        cycle(0, 0, 0, 32'd0);
        cycle(0, 0, 1, 32'h40);
        chk1("drop_valid0", if_valid, 1'b0);
        chk("drop_addr0", bus.imem_addr, 32'd8);
        cycle(0, 0, 0, 32'd0);
        chk1("drop_valid1", if_valid, 1'b0);
        chk("drop_addr1", bus.imem_addr, 32'd8);
        cycle(0, 0, 0, 32'd0);
        chk1("redir_valid", if_valid, 1'b0);
        chk1("redir_req", bus.imem_req, 1'b1);
        chk("redir_addr", bus.imem_addr, 32'h40);

        // branch with simultaneous response and stall
        fixedLat = 0;
        for (int i = 0; i < 20 && !if_valid; i++) cycle(0, 0, 0, 32'd0);
        chk1("s4_valid", if_valid, 1'b1);
        chk1("s4_req", bus.imem_req, 1'b1);
        cycle(0, 1, 1, 32'h103);
        chk1("s4_flush", if_valid, 1'b0);
        chk("s4_addr", bus.imem_addr, 32'h100);
        cycle(0, 0, 0, 32'd0);
        chk("s4_instr", if_instr, 32'h40);
        chk("s4_pc4", if_pc4, 32'h104);

        // redirect to the top word and wrap
        cycle(0, 0, 1, 32'hFFFF_FFFE);
        chk("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 32'd0);
        chk("top_pc4", if_pc4, 32'd0);
        chk("top_next_addr", bus.imem_addr, 32'd0);

        // reset while holding a skid entry
        cycle(0, 1, 0, 32'd0);
        chk1("hold_req", bus.imem_req, 1'b0);
        cycle(1, 0, 0, 32'd0);
        chk1("hreset_valid", if_valid, 1'b0);
        chk("hreset_pc4", if_pc4, 32'd0);
        chk1("hreset_req", bus.imem_req, 1'b0);

        // randomized traffic
        rawData  = 0;
        fixedLat = -1;
        cycle(1, 0, 0, 32'd0);
        consumed = 0;
        for (int n = 0; n < 6000; n++) begin
            bit          r, s, b;
            logic [31:0] t;
            if (n % 500 == 0) maxLat = int'($urandom_range(3, 0));
            r = ($urandom_range(299, 0) == 0);
            s = ($urandom_range(2, 0) == 0);
            b = ($urandom_range(11, 0) == 0);
            t = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + ($urandom % 16)
                                            : $urandom;
            cycle(r, s, b, t);
        end
        cycle(0, 0, 0, 32'd0);
        chk1("progress", consumed > 1000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
